// File: rtl/bp_call_ret.sv
// bp_call_ret: pre-decode call/return/branch predictor between fetch and decode.
// Classifies each accepted fetch packet using RISC-V link-register hints
// (x1/x5), drives the return-address-stack push/pop/address lines, and
// registers a jump/next-PC prediction behind a single-entry valid/ready stage.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module bp_call_ret (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_bp_valid,
  input  logic [`ADDR_WIDTH-1:0]   fetch_bp_pc,
  input  logic [31:0]              fetch_bp_instruction,
  output logic                     bp_fetch_ready,
  input  logic                     commit_bp_flush,
  output logic [`ADDR_WIDTH-1:0]   bp_ras_addr,
  output logic                     bp_ras_push,
  output logic                     bp_ras_pop,
  input  logic [`ADDR_WIDTH-1:0]   ras_bp_addr,
  output logic                     bp_decode_valid,
  output logic [`ADDR_WIDTH-1:0]   bp_decode_pc,
  output logic [31:0]              bp_decode_instruction,
  output logic                     bp_decode_jump,
  output logic [`ADDR_WIDTH-1:0]   bp_decode_next_pc,
  input  logic                     decode_bp_ready,
  output logic                     bp_csrf_call_add,
  output logic                     bp_csrf_ret_add
);

  localparam int AW = `ADDR_WIDTH;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // x1 (ra) and x5 (t0) are the link registers used as call/return hints.
  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  // J-type immediate from instruction bits [31:12], sign-extended to AW.
  function automatic logic [AW-1:0] j_imm(input logic [19:0] f);
    logic [20:0] imm;
    imm = {f[19], f[7:0], f[8], f[18:9], 1'b0};
    return {{(AW-21){imm[20]}}, imm};
  endfunction

  // B-type immediate from bits [31:25] and [11:7], sign-extended to AW.
  function automatic logic [AW-1:0] b_imm(input logic [6:0] hi, input logic [4:0] lo);
    logic [12:0] imm;
    imm = {hi[6], lo[0], hi[5:0], lo[4:1], 1'b0};
    return {{(AW-13){imm[12]}}, imm};
  endfunction

  logic [6:0]    opcode_s;
  logic [4:0]    rd_s;
  logic [4:0]    rs1_s;
  logic          rd_link_s;
  logic          rs1_link_s;
  logic [AW-1:0] pc_plus4_s;
  logic [AW-1:0] b_imm_s;
  logic          fire_s;
  logic          jump_s;
  logic [AW-1:0] next_pc_s;
  logic          push_s;
  logic          pop_s;

  logic          valid_r;
  logic [AW-1:0] pc_r;
  logic [31:0]   instr_r;
  logic          jump_r;
  logic [AW-1:0] next_pc_r;
  logic          call_r;
  logic          ret_r;

  assign opcode_s   = fetch_bp_instruction[6:0];
  assign rd_s       = fetch_bp_instruction[11:7];
  assign rs1_s      = fetch_bp_instruction[19:15];
  assign rd_link_s  = is_link(rd_s);
  assign rs1_link_s = is_link(rs1_s);
  assign pc_plus4_s = fetch_bp_pc + AW'(32'd4);
  assign b_imm_s    = b_imm(fetch_bp_instruction[31:25], fetch_bp_instruction[11:7]);

  // Single-entry output stage: accept whenever empty or being drained.
  assign bp_fetch_ready = !valid_r || decode_bp_ready;
  assign fire_s         = fetch_bp_valid && bp_fetch_ready && !commit_bp_flush;

  // Classify the incoming packet and form the prediction and RAS intent.
  always_comb begin
    jump_s    = 1'b0;
    next_pc_s = pc_plus4_s;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    case (opcode_s)
      OPC_JAL: begin
        jump_s    = 1'b1;
        next_pc_s = fetch_bp_pc + j_imm(fetch_bp_instruction[31:12]);
        push_s    = rd_link_s;
      end
      OPC_JALR: begin
        if (rd_link_s && rs1_link_s && (rd_s != rs1_s)) begin
          // Coroutine swap: return to the stacked address, push our own link.
          push_s    = 1'b1;
          pop_s     = 1'b1;
          jump_s    = 1'b1;
          next_pc_s = ras_bp_addr;
        end else if (rd_link_s) begin
          // Indirect call: target unknown here, only record the return address.
          push_s    = 1'b1;
        end else if (rs1_link_s) begin
          pop_s     = 1'b1;
          jump_s    = 1'b1;
          next_pc_s = ras_bp_addr;
        end else begin
          push_s    = 1'b0;
          pop_s     = 1'b0;
        end
      end
      OPC_BRANCH: begin
        // Backward-taken / forward-not-taken static prediction.
        if (b_imm_s[AW-1]) begin
          jump_s    = 1'b1;
          next_pc_s = fetch_bp_pc + b_imm_s;
        end else begin
          jump_s    = 1'b0;
          next_pc_s = pc_plus4_s;
        end
      end
      default: begin
        jump_s    = 1'b0;
        next_pc_s = pc_plus4_s;
      end
    endcase
  end

  // RAS control lines are only live for a packet that actually fires.
  always_comb begin
    bp_ras_push = 1'b0;
    bp_ras_pop  = 1'b0;
    bp_ras_addr = '0;
    if (fire_s) begin
      bp_ras_push = push_s;
      bp_ras_pop  = pop_s;
      bp_ras_addr = push_s ? pc_plus4_s : '0;
    end else begin
      bp_ras_push = 1'b0;
      bp_ras_pop  = 1'b0;
      bp_ras_addr = '0;
    end
  end

  // Output register: flush beats fire beats drain; stalls hold everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r   <= 1'b0;
      pc_r      <= '0;
      instr_r   <= 32'd0;
      jump_r    <= 1'b0;
      next_pc_r <= '0;
      call_r    <= 1'b0;
      ret_r     <= 1'b0;
    end else if (commit_bp_flush) begin
      valid_r   <= 1'b0;
      call_r    <= 1'b0;
      ret_r     <= 1'b0;
    end else if (fire_s) begin
      valid_r   <= 1'b1;
      pc_r      <= fetch_bp_pc;
      instr_r   <= fetch_bp_instruction;
      jump_r    <= jump_s;
      next_pc_r <= next_pc_s;
      call_r    <= push_s;
      ret_r     <= pop_s;
    end else begin
      call_r    <= 1'b0;
      ret_r     <= 1'b0;
      if (decode_bp_ready) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign bp_decode_valid       = valid_r;
  assign bp_decode_pc          = pc_r;
  assign bp_decode_instruction = instr_r;
  assign bp_decode_jump        = jump_r;
  assign bp_decode_next_pc     = next_pc_r;
  assign bp_csrf_call_add      = call_r;
  assign bp_csrf_ret_add       = ret_r;

endmodule

// File: tb/tb_bp_call_ret.sv
// Randomized scoreboard bench for bp_call_ret with a behavioural RAS and
// prediction model. The driver pushes expected entries; a monitor compares.
module tb_bp_call_ret;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_bp_valid = 1'b0;
  logic [31:0] fetch_bp_pc = 32'd0;
  logic [31:0] fetch_bp_instruction = 32'd0;
  logic        bp_fetch_ready;
  logic        commit_bp_flush = 1'b0;
  logic [31:0] bp_ras_addr;
  logic        bp_ras_push;
  logic        bp_ras_pop;
  logic [31:0] ras_bp_addr = 32'd0;
  logic        bp_decode_valid;
  logic [31:0] bp_decode_pc;
  logic [31:0] bp_decode_instruction;
  logic        bp_decode_jump;
  logic [31:0] bp_decode_next_pc;
  logic        decode_bp_ready = 1'b0;
  logic        bp_csrf_call_add;
  logic        bp_csrf_ret_add;

  bp_call_ret dut (
    .clk(clk), .rst(rst),
    .fetch_bp_valid(fetch_bp_valid), .fetch_bp_pc(fetch_bp_pc),
    .fetch_bp_instruction(fetch_bp_instruction), .bp_fetch_ready(bp_fetch_ready),
    .commit_bp_flush(commit_bp_flush),
    .bp_ras_addr(bp_ras_addr), .bp_ras_push(bp_ras_push), .bp_ras_pop(bp_ras_pop),
    .ras_bp_addr(ras_bp_addr),
    .bp_decode_valid(bp_decode_valid), .bp_decode_pc(bp_decode_pc),
    .bp_decode_instruction(bp_decode_instruction), .bp_decode_jump(bp_decode_jump),
    .bp_decode_next_pc(bp_decode_next_pc), .decode_bp_ready(decode_bp_ready),
    .bp_csrf_call_add(bp_csrf_call_add), .bp_csrf_ret_add(bp_csrf_ret_add)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        jump;
    logic [31:0] next;
  } entry_t;

  typedef struct {
    logic        jump;
    logic [31:0] next;
    logic        push;
    logic        pop;
  } pred_t;

  entry_t      sb[$];
  logic [31:0] stk[$];
  int          total = 0;
  int          passed = 0;
  logic        mon_en = 1'b0;
  logic        exp_call = 1'b0;
  logic        exp_ret = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  // Behavioural prediction straight from the classification rules.
  function automatic pred_t predict(input logic [31:0] pc, input logic [31:0] ins,
                                    input logic [31:0] ras);
    pred_t p;
    int rd, rs1, imm;
    bit rdl, rsl;
    logic signed [20:0] jimm;
    logic signed [12:0] bimm;
    rd   = int'(ins[11:7]);
    rs1  = int'(ins[19:15]);
    rdl  = (rd == 1) || (rd == 5);
    rsl  = (rs1 == 1) || (rs1 == 5);
    p.jump = 1'b0; p.next = pc + 32'd4; p.push = 1'b0; p.pop = 1'b0;
    if (ins[6:0] == 7'b1101111) begin
      jimm = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      imm = int'(jimm);
      p.jump = 1'b1; p.next = pc + imm; p.push = rdl;
    end else if (ins[6:0] == 7'b1100111) begin
      p.push = rdl;
      p.pop  = rsl && !(rdl && rd == rs1);
      if (p.pop) begin p.jump = 1'b1; p.next = ras; end
    end else if (ins[6:0] == 7'b1100011) begin
      bimm = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      imm = int'(bimm);
      if (imm < 0) begin p.jump = 1'b1; p.next = pc + imm; end
    end
    return p;
  endfunction

  // One cycle of stimulus: drive, check RAS lines, then update the model.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic fl, input logic dr);
    logic  exp_ready, fire;
    pred_t p;
    entry_t e;
    @(negedge clk);
    fetch_bp_valid = v; fetch_bp_pc = pc; fetch_bp_instruction = ins;
    commit_bp_flush = fl; decode_bp_ready = dr;
    ras_bp_addr = (stk.size() > 0) ? stk[$] : $urandom();
    exp_ready = (sb.size() == 0) || dr;
    fire = v && exp_ready && !fl;
    p = predict(pc, ins, ras_bp_addr);
    #1;
    check("fetch_ready", 32'(bp_fetch_ready), 32'(exp_ready));
    check("ras_push", 32'(bp_ras_push), 32'(fire && p.push));
    check("ras_pop", 32'(bp_ras_pop), 32'(fire && p.pop));
    if (!fire || p.push) check("ras_addr", bp_ras_addr, (fire && p.push) ? pc + 32'd4 : 32'd0);
    #2;
    if (fl) sb.delete();
    else if (fire) begin
      e.pc = pc; e.instr = ins; e.jump = p.jump; e.next = p.next;
      sb.push_back(e);
    end
    exp_call = fire && p.push;
    exp_ret  = fire && p.pop;
    if (fire && p.pop && stk.size() > 0) void'(stk.pop_back());
    if (fire && p.push) stk.push_back(pc + 32'd4);
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en = 1'b0; rst = 1'b1; fetch_bp_valid = 1'b0; commit_bp_flush = 1'b0;
    decode_bp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete(); exp_call = 1'b0; exp_ret = 1'b0;
    #1;
    check("rst_valid", 32'(bp_decode_valid), 32'd0);
    check("rst_pc", bp_decode_pc, 32'd0);
    check("rst_instr", bp_decode_instruction, 32'd0);
    check("rst_jump", 32'(bp_decode_jump), 32'd0);
    check("rst_next", bp_decode_next_pc, 32'd0);
    check("rst_call", 32'(bp_csrf_call_add), 32'd0);
    check("rst_ret", 32'(bp_csrf_ret_add), 32'd0);
    check("rst_ready", 32'(bp_fetch_ready), 32'd1);
    check("rst_ras", {bp_ras_addr[29:0], bp_ras_push, bp_ras_pop}, 32'd0);
    mon_en = 1'b1;
  endtask

  // Monitor: compares the presented entry and pulses every cycle, pops on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        check("dec_valid", 32'(bp_decode_valid), 32'(sb.size() != 0));
        check("call_pulse", 32'(bp_csrf_call_add), 32'(exp_call));
        check("ret_pulse", 32'(bp_csrf_ret_add), 32'(exp_ret));
        if (sb.size() > 0) begin
          check("dec_pc", bp_decode_pc, sb[0].pc);
          check("dec_instr", bp_decode_instruction, sb[0].instr);
          check("dec_jump", 32'(bp_decode_jump), 32'(sb[0].jump));
          check("dec_next", bp_decode_next_pc, sb[0].next);
          if (decode_bp_ready && !commit_bp_flush) void'(sb.pop_front());
        end
      end
    end
  end

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 4))
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd5;
      3: return 5'd2;
      default: return 5'($urandom());
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 3))
      0: return {r[31:12], pick_reg(), 7'b1101111};
      1: return {r[31:20], pick_reg(), 3'b000, pick_reg(), 7'b1100111};
      2: return {r[31:7], 7'b1100011};
      default: return r;
    endcase
  endfunction

  initial begin
    logic [31:0] pc;
    do_reset();
    // Call then return through the bench RAS.
    cycle(1'b1, 32'h80000000, 32'h100000EF, 1'b0, 1'b1);
    cycle(1'b1, 32'h80000100, 32'h00008067, 1'b0, 1'b1);
    // Backpressure: entry held 3 cycles while a call is offered, then accepted.
    cycle(1'b1, 32'h00001000, 32'h00000013, 1'b0, 1'b1);
    repeat (3) cycle(1'b1, 32'h00001004, 32'h100000EF, 1'b0, 1'b0);
    cycle(1'b1, 32'h00001004, 32'h100000EF, 1'b0, 1'b1);
    // Flush alongside a call fire.
    cycle(1'b1, 32'h00001100, 32'h100000EF, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    // Branches backward and forward.
    cycle(1'b1, 32'h00001000, 32'hFE000CE3, 1'b0, 1'b1);
    cycle(1'b1, 32'h00001000, 32'h00000463, 1'b0, 1'b1);
    // Coroutine jalr x1, 0(x5) with RAS top 0x3000.
    stk.push_back(32'h00003000);
    cycle(1'b1, 32'h00002000, 32'h000280E7, 1'b0, 1'b1);
    // pc+4 wraparound.
    cycle(1'b1, 32'hFFFFFFFC, 32'h00000013, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    // Reset while an entry is stalled.
    cycle(1'b1, 32'h00004000, 32'h00000013, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    do_reset();
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : ($urandom() & 32'hFFFFFFFC);
      cycle(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, pc, rand_instr(),
            ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
      if (stk.size() > 64) void'(stk.pop_front());
    end
    repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bp_call_ret.md
# bp_call_ret

Pre-decode branch predictor stage between instruction fetch and decode. Each accepted fetch packet is classified as call, return, jump or branch using RISC-V link-register hints, and the block drives the push/pop/address inputs of the return-address stack. Its output is a registered prediction (jump flag plus next PC) behind a valid/ready handshake toward decode. It also reports call/return counts to the CSR file.

## Interface
- No parameters. Address width is `ADDR_WIDTH` from config.svh (32). Instructions are 32-bit only; compressed instructions are not supported.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- fetch_bp_valid  in  1  fetch packet valid
- fetch_bp_pc  in  ADDR_WIDTH  packet PC
- fetch_bp_instruction  in  32  packet instruction
- bp_fetch_ready  out  1  stage can accept a packet
- commit_bp_flush  in  1  pipeline flush
- bp_ras_addr  out  ADDR_WIDTH  return address to push
- bp_ras_push  out  1  RAS push
- bp_ras_pop  out  1  RAS pop
- ras_bp_addr  in  ADDR_WIDTH  current RAS top, combinational, pre-update
- bp_decode_valid  out  1  prediction valid
- bp_decode_pc  out  ADDR_WIDTH  registered packet PC
- bp_decode_instruction  out  32  registered instruction
- bp_decode_jump  out  1  predicted taken
- bp_decode_next_pc  out  ADDR_WIDTH  predicted next PC
- decode_bp_ready  in  1  decode accepts
- bp_csrf_call_add  out  1  one-cycle pulse per call
- bp_csrf_ret_add  out  1  one-cycle pulse per return

## Operation
- **fire** = fetch_bp_valid && bp_fetch_ready && !commit_bp_flush.
- A register is a **link** if it is x1 or x5.
- Opcode 1101111 (JAL):
  - jump = 1, next = pc + sign-extended J-immediate.
  - If rd is a link: push pc+4 and count a call.
- Opcode 1100111 (JALR):
  - rd link, rs1 not link: push pc+4 (call). jump = 0, next = pc+4.
  - rd not link, rs1 link: pop (return). jump = 1, next = ras_bp_addr.
  - rd link, rs1 link, rd != rs1: push and pop in the same cycle (call and return). jump = 1, next = ras_bp_addr; bp_ras_addr = pc+4.
  - rd link, rs1 link, rd == rs1: push only (call). jump = 0, next = pc+4.
  - Neither is a link: no RAS operation. jump = 0, next = pc+4.
- Opcode 1100011 (branch), backward-taken/forward-not-taken:
  - Negative B-immediate: jump = 1, next = pc + imm.
  - Otherwise: jump = 0, next = pc+4.
- Any other opcode: jump = 0, next = pc+4.
- bp_ras_push, bp_ras_pop and bp_ras_addr are combinational. They are asserted only on fire; otherwise push = pop = 0 and bp_ras_addr = 0.
- ras_bp_addr is used even when the RAS is empty (the value is stale, 0 after reset). No empty check is made.
- All address arithmetic is modulo 2^ADDR_WIDTH; pc+4 wraps from 0xFFFFFFFC to 0.

## Timing
- The output register is a single entry. bp_fetch_ready = !bp_decode_valid || decode_bp_ready (combinational).
- Prediction latency is 1 cycle: a packet fired in cycle N appears on bp_decode_* in N+1.
- On fire the output register loads. If the register holds data and decode_bp_ready = 0, all bp_decode_* outputs hold stable.
- With no fire, bp_decode_valid clears when the current entry is accepted.
- commit_bp_flush:
  - bp_decode_valid is 0 the next cycle.
  - No RAS operation occurs that cycle.
  - The flush takes priority over a simultaneous fire and a simultaneous handshake.
- The RAS update is visible to ras_bp_addr in the cycle after a push or pop. Back-to-back returns therefore see the correct successive tops.
- bp_csrf_call_add and bp_csrf_ret_add are registered and pulse in N+1 for a fire in N. A push+pop JALR pulses both.
- Reset values: bp_decode_valid = 0, bp_decode_pc = 0, bp_decode_instruction = 0, bp_decode_jump = 0, bp_decode_next_pc = 0, bp_csrf_call_add = 0, bp_csrf_ret_add = 0.
- After reset, bp_fetch_ready = 1 and the RAS outputs are 0.
- A reset mid-stall discards the held entry.

## Test plan
- **Call:** pc 0x80000000, instruction 0x100000EF (jal x1, +0x100), decode ready.
  - Same cycle: bp_ras_push = 1, bp_ras_addr = 0x80000004.
  - Next cycle: valid = 1, jump = 1, next_pc = 0x80000100, call pulse = 1.
- **Return:** ras_bp_addr = 0x80000004, pc 0x80000100, instruction 0x00008067 (ret).
  - Same cycle: bp_ras_pop = 1, no push.
  - Next cycle: jump = 1, next_pc = 0x80000004, return pulse = 1.
- **Backpressure:** decode_bp_ready = 0 for 3 cycles with a valid entry held.
  - bp_fetch_ready = 0 and outputs stable.
  - A fetch packet offered in that time causes no push or pop.
  - The packet is accepted the cycle ready returns.
- **Flush:** commit_bp_flush = 1 in the same cycle as a jal x1 fire.
  - No push occurs.
  - bp_decode_valid = 0 next cycle, call pulse = 0.
- **Branches:** pc 0x1000.
  - beq with imm -8: jump = 1, next_pc = 0x0FF8.
  - beq with imm +8: jump = 0, next_pc = 0x1004.
- **Coroutine JALR:** jalr x1, 0(x5) at pc 0x2000, ras_bp_addr = 0x3000.
  - Same cycle: push = 1 and pop = 1, bp_ras_addr = 0x2004.
  - Next cycle: next_pc = 0x3000, both pulses = 1.
